// File: rtl/bot_if_pkg.sv
// bot_if_pkg: shared constants and types for the Rojobot application-side register interface.
// Contents: read/write port offsets, status bit positions, motor stop code, snapshot struct.
// Optional feature macro used by the importing files: BOTIF_OVERRUN_CNT_EN.
package bot_if_pkg;

   // Read offsets (port_id[2:0])
   localparam logic [2:0] RD_LOCX    = 3'd0;
   localparam logic [2:0] RD_LOCY    = 3'd1;
   localparam logic [2:0] RD_SENSORS = 3'd2;
   localparam logic [2:0] RD_BOTINFO = 3'd3;
   localparam logic [2:0] RD_LMDIST  = 3'd4;
   localparam logic [2:0] RD_RMDIST  = 3'd5;
   localparam logic [2:0] RD_STATUS  = 3'd6;
   localparam logic [2:0] RD_OVERRUN = 3'd7;

   // Write offsets (port_id[2:0])
   localparam logic [2:0] WR_MOTCTL  = 3'd0;
   localparam logic [2:0] WR_CONFIG  = 3'd1;
   localparam logic [2:0] WR_ACK     = 3'd2;
   localparam logic [2:0] WR_CLR_OVR = 3'd3;

   // Status register bit positions
   localparam int STAT_NEW_DATA = 0;
   localparam int STAT_IRQ_PEND = 1;

   localparam logic [7:0] MOTCTL_STOP = 8'h00;
   localparam logic [7:0] OVR_MAX     = 8'hFF;

   // Coherent copy of the six BOTSIM registers
   typedef struct packed {
      logic [7:0] locx;
      logic [7:0] locy;
      logic [7:0] sensors;
      logic [7:0] botinfo;
      logic [7:0] lmdist;
      logic [7:0] rmdist;
   } snap_t;

endpackage

// File: rtl/bot_if_snapshot.sv
// bot_if_snapshot: detects a rising edge of upd_sysregs and loads all six shadow registers together.
// Ports: clk/reset; upd_sysregs and the six BOTSIM *_in bytes in; capture pulse and snapshot bus out.
// Timing: upd_sysregs high in cycle N -> capture high in N+1 -> snap valid in N+2.
module bot_if_snapshot
   import bot_if_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       upd_sysregs,
   input  logic [7:0] LocX_in,
   input  logic [7:0] LocY_in,
   input  logic [7:0] Sensors_in,
   input  logic [7:0] BotInfo_in,
   input  logic [7:0] LMDist_in,
   input  logic [7:0] RMDist_in,
   output logic       capture,
   output snap_t      snap
);

   logic upd_r;   // upd_sysregs registered once
   logic upd_d;   // previous value of upd_r, for edge detection

   // Both flops clear on reset, so a level already high at release is seen as a new edge.
   assign capture = upd_r & ~upd_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upd_r <= 1'b0;
         upd_d <= 1'b0;
         snap  <= '0;
      end else begin
         upd_r <= upd_sysregs;
         upd_d <= upd_r;
         if (capture) begin
            snap <= '{locx:    LocX_in,
                      locy:    LocY_in,
                      sensors: Sensors_in,
                      botinfo: BotInfo_in,
                      lmdist:  LMDist_in,
                      rmdist:  RMDist_in};
         end
      end
   end

endmodule

// File: rtl/bot_app_if.sv
// bot_app_if: PicoBlaze I/O port bridge between the application CPU and the BOTSIM register set.
// Ports: clk/reset; PicoBlaze port_id/out_port/strobes/in_port/interrupt/ack; BOTSIM *_in, upd_sysregs,
//        MotCtl_out, Bot_Config_out. Define BOTIF_OVERRUN_CNT_EN to build the overrun counter.
module bot_app_if
   import bot_if_pkg::*;
#(
   parameter logic [7:0] PORT_BASE    = 8'h00,
   parameter logic [7:0] CONFIG_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic [7:0] LocX_in,
   input  logic [7:0] LocY_in,
   input  logic [7:0] Sensors_in,
   input  logic [7:0] BotInfo_in,
   input  logic [7:0] LMDist_in,
   input  logic [7:0] RMDist_in,
   input  logic       upd_sysregs,
   output logic [7:0] MotCtl_out,
   output logic [7:0] Bot_Config_out
);

   logic       capture;
   snap_t      snap;
   logic       addr_hit;
   logic [2:0] offset;
   logic       wr_en;
   logic       ack_wr;
   logic       new_data;
   logic       irq_pend;
   logic [7:0] ovr_cnt;
   logic [7:0] rd_dat;

   // Reads have no side effects, so the read qualifier carries no information here.
   logic unused_rd_strobe;
   assign unused_rd_strobe = read_strobe;

   bot_if_snapshot u_snapshot (
      .clk         (clk),
      .reset       (reset),
      .upd_sysregs (upd_sysregs),
      .LocX_in     (LocX_in),
      .LocY_in     (LocY_in),
      .Sensors_in  (Sensors_in),
      .BotInfo_in  (BotInfo_in),
      .LMDist_in   (LMDist_in),
      .RMDist_in   (RMDist_in),
      .capture     (capture),
      .snap        (snap)
   );

   assign addr_hit = (port_id[7:3] == PORT_BASE[7:3]);
   assign offset   = port_id[2:0];
   assign wr_en    = write_strobe & addr_hit;
   assign ack_wr   = wr_en & (offset == WR_ACK);

   // Control registers and flags. A capture outranks ACK and interrupt_ack in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MotCtl_out     <= MOTCTL_STOP;
         Bot_Config_out <= CONFIG_RESET;
         new_data       <= 1'b0;
         irq_pend       <= 1'b0;
      end else begin
         if (wr_en && offset == WR_MOTCTL) MotCtl_out     <= out_port;
         if (wr_en && offset == WR_CONFIG) Bot_Config_out <= out_port;

         if (capture)     new_data <= 1'b1;
         else if (ack_wr) new_data <= 1'b0;

         if (capture)            irq_pend <= 1'b1;
         else if (interrupt_ack) irq_pend <= 1'b0;
      end
   end

   assign interrupt = irq_pend;

`ifdef BOTIF_OVERRUN_CNT_EN
   logic clr_ovr_wr;
   assign clr_ovr_wr = wr_en & (offset == WR_CLR_OVR);

   // A capture that lands together with its ACK is not an overrun; clear beats increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_cnt <= 8'h00;
      end else if (clr_ovr_wr) begin
         ovr_cnt <= 8'h00;
      end else if (capture && new_data && !ack_wr && ovr_cnt != OVR_MAX) begin
         ovr_cnt <= ovr_cnt + 8'h01;
      end
   end
`else
   assign ovr_cnt = 8'h00;
`endif

   always_comb begin
      rd_dat = 8'h00;
      if (addr_hit) begin
         case (offset)
            RD_LOCX:    rd_dat = snap.locx;
            RD_LOCY:    rd_dat = snap.locy;
            RD_SENSORS: rd_dat = snap.sensors;
            RD_BOTINFO: rd_dat = snap.botinfo;
            RD_LMDIST:  rd_dat = snap.lmdist;
            RD_RMDIST:  rd_dat = snap.rmdist;
            RD_STATUS: begin
               rd_dat[STAT_NEW_DATA] = new_data;
               rd_dat[STAT_IRQ_PEND] = irq_pend;
            end
            RD_OVERRUN: rd_dat = ovr_cnt;
            default:    rd_dat = 8'h00;
         endcase
      end
   end

   // Read data is registered every cycle regardless of read_strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_port <= 8'h00;
      else       in_port <= rd_dat;
   end

endmodule

// File: tb/tb_bot_app_if.sv
// tb_bot_app_if: directed bench for bot_app_if with a register-level reference model.
// The model tracks the programmer-visible registers; a negedge process compares every cycle.
// Honours BOTIF_OVERRUN_CNT_EN for the overrun expectations.
module tb_bot_app_if;

   localparam logic [7:0] BASE    = 8'h10;
   localparam logic [7:0] CFG_RST = 8'h3C;
`ifdef BOTIF_OVERRUN_CNT_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id, out_port;
   logic       write_strobe, read_strobe, interrupt_ack, upd_sysregs;
   logic [7:0] LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in;
   logic [7:0] in_port, MotCtl_out, Bot_Config_out;
   logic       interrupt;

   always #5 clk = ~clk;

   bot_app_if #(.PORT_BASE(BASE), .CONFIG_RESET(CFG_RST)) dut (
      .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
      .interrupt(interrupt), .interrupt_ack(interrupt_ack),
      .LocX_in(LocX_in), .LocY_in(LocY_in), .Sensors_in(Sensors_in),
      .BotInfo_in(BotInfo_in), .LMDist_in(LMDist_in), .RMDist_in(RMDist_in),
      .upd_sysregs(upd_sysregs), .MotCtl_out(MotCtl_out), .Bot_Config_out(Bot_Config_out)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: programmer-visible register contents
   logic [7:0] m_reg [0:5];
   logic       m_new, m_irq;
   logic [7:0] m_ovr, m_mot, m_cfg;
   bit         chk_on = 1'b0;
   bit         exp_vld = 1'b0;
   logic [7:0] exp_in;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_read(input logic [7:0] pid);
      if (pid[7:3] != BASE[7:3]) return 8'h00;
      case (pid[2:0])
         3'd6:    return {6'b0, m_irq, m_new};
         3'd7:    return OVR_EN ? m_ovr : 8'h00;
         default: return m_reg[pid[2:0]];
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
      m_new = 0; m_irq = 0; m_ovr = 8'h00; m_mot = 8'h00; m_cfg = CFG_RST;
   endtask

   task automatic m_capture(input bit ack_same);
      if (m_new && !ack_same && m_ovr != 8'hFF) m_ovr = m_ovr + 8'h01;
      m_new = 1; m_irq = 1;
      m_reg[0] = LocX_in; m_reg[1] = LocY_in; m_reg[2] = Sensors_in;
      m_reg[3] = BotInfo_in; m_reg[4] = LMDist_in; m_reg[5] = RMDist_in;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_in(input logic [7:0] a, b, c, d, e, f);
      LocX_in = a; LocY_in = b; Sensors_in = c; BotInfo_in = d; LMDist_in = e; RMDist_in = f;
   endtask

   task automatic wr(input logic [7:0] pid, input logic [7:0] dat);
      port_id = pid; out_port = dat; write_strobe = 1; tick(); write_strobe = 0;
      if (pid[7:3] == BASE[7:3]) begin
         case (pid[2:0])
            3'd0: m_mot = dat;
            3'd1: m_cfg = dat;
            3'd2: m_new = 0;
            3'd3: m_ovr = 8'h00;
            default: ;
         endcase
      end
   endtask

   task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string name);
      port_id = BASE + {5'b0, off}; tick();
      check(name, in_port, exp);
   endtask

   task automatic pulse();
      upd_sysregs = 1; tick(); upd_sysregs = 0; tick(); m_capture(0);
   endtask

   // Capture lands on the same edge as an ACK write, interrupt_ack or clear-overrun write
   task automatic cap_with(input bit ack_wr, input bit iack, input bit clr);
      upd_sysregs = 1; tick(); upd_sysregs = 0;
      if (ack_wr) port_id = BASE + 8'd2;
      if (clr)    port_id = BASE + 8'd3;
      write_strobe = ack_wr | clr; interrupt_ack = iack;
      tick();
      write_strobe = 0; interrupt_ack = 0;
      m_capture(ack_wr);
      if (clr) m_ovr = 8'h00;
   endtask

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_on && !reset) begin
         check("interrupt", {7'b0, interrupt}, {7'b0, m_irq});
         check("MotCtl_out", MotCtl_out, m_mot);
         check("Bot_Config_out", Bot_Config_out, m_cfg);
         if (exp_vld) check("in_port", in_port, exp_in);
         exp_in  = m_read(port_id);
         exp_vld = 1'b1;
      end
   end

   initial begin
      reset = 1; port_id = 8'h00; out_port = 8'h00; write_strobe = 0; read_strobe = 0;
      interrupt_ack = 0; upd_sysregs = 0;
      set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      m_reset();
      repeat (3) @(posedge clk);
      #1 reset = 0;
      check("rst interrupt", {7'b0, interrupt}, 8'h00);
      check("rst MotCtl", MotCtl_out, 8'h00);
      check("rst Config", Bot_Config_out, 8'h3C);
      check("rst in_port", in_port, 8'h00);
      chk_on = 1;
      for (int i = 0; i < 8; i++) rd(i[2:0], 8'h00, "rst read");

      // First capture and snapshot coherence
      set_in(8'h12, 8'h34, 8'h05, 8'h81, 8'h56, 8'h78);
      pulse();
      check("irq after capture", {7'b0, interrupt}, 8'h01);
      rd(3'd0, 8'h12, "LocX"); rd(3'd1, 8'h34, "LocY");
      rd(3'd2, 8'h05, "Sensors"); rd(3'd3, 8'h81, "BotInfo");
      rd(3'd4, 8'h56, "LMDist"); rd(3'd5, 8'h78, "RMDist");
      rd(3'd6, 8'h03, "Status new+irq");
      set_in(8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF);
      repeat (3) tick();
      rd(3'd0, 8'h12, "LocX held"); rd(3'd5, 8'h78, "RMDist held");

      // Acknowledge paths
      interrupt_ack = 1; tick(); interrupt_ack = 0; m_irq = 0;
      rd(3'd6, 8'h01, "Status after iack");
      wr(BASE + 8'd2, 8'h99);
      rd(3'd6, 8'h00, "Status after ACK");

      // Overrun counting and saturation
      repeat (3) pulse();
      rd(3'd7, OVR_EN ? 8'h02 : 8'h00, "Overrun 3 caps");
      rd(3'd0, 8'hAA, "LocX new");
      repeat (300) pulse();
      rd(3'd7, OVR_EN ? 8'hFF : 8'h00, "Overrun saturated");
      wr(BASE + 8'd3, 8'h00);
      rd(3'd7, 8'h00, "Overrun cleared");

      // Output registers and address decode
      wr(8'h10, 8'h5A); wr(8'h11, 8'h03);
      check("MotCtl write", MotCtl_out, 8'h5A);
      check("Config write", Bot_Config_out, 8'h03);
      wr(8'h20, 8'hC1); wr(8'h21, 8'hC2); wr(8'h22, 8'h00);
      check("MotCtl decode", MotCtl_out, 8'h5A);
      check("Config decode", Bot_Config_out, 8'h03);
      port_id = 8'h26; tick(); check("unmatched read", in_port, 8'h00);
      rd(3'd6, 8'h03, "Status after foreign ACK");

      // Coincident events
      cap_with(1, 0, 0);
      rd(3'd6, 8'h03, "cap+ACK status");
      rd(3'd7, 8'h00, "cap+ACK overrun");
      wr(BASE + 8'd2, 8'h00);
      cap_with(0, 1, 0);
      rd(3'd6, 8'h03, "cap+iack status");
      rd(3'd7, 8'h00, "cap+iack overrun");
      pulse();
      rd(3'd7, OVR_EN ? 8'h01 : 8'h00, "Overrun one");
      cap_with(0, 0, 1);
      rd(3'd7, 8'h00, "cap+clr overrun");

      // Held level gives a single capture
      wr(BASE + 8'd2, 8'h00);
      upd_sysregs = 1; tick(); tick(); m_capture(0);
      repeat (5) tick();
      upd_sysregs = 0; tick();
      rd(3'd6, 8'h03, "level status");
      rd(3'd7, 8'h00, "level overrun");

      // Asynchronous reset mid-operation; upd high at release counts as an edge
      wr(8'h10, 8'h77);
      #2 reset = 1;
      #1;
      check("arst interrupt", {7'b0, interrupt}, 8'h00);
      check("arst MotCtl", MotCtl_out, 8'h00);
      check("arst Config", Bot_Config_out, 8'h3C);
      check("arst in_port", in_port, 8'h00);
      exp_vld = 0; m_reset();
      upd_sysregs = 1; port_id = BASE;
      @(posedge clk); #1 reset = 0;
      tick();
      check("post-reset LocX", in_port, 8'h00);
      tick(); m_capture(0);
      upd_sysregs = 0;
      rd(3'd6, 8'h03, "release edge status");
      rd(3'd0, 8'hAA, "release edge LocX");
      rd(3'd7, 8'h00, "release edge overrun");
      tick();

      chk_on = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bot_app_if.md
# bot_app_if

Application-CPU side of the Rojobot register interface: bridges the BOTSIM system registers (LocX, LocY, Sensors, BotInfo, LMDist, RMDist, upd_sysregs) to the application PicoBlaze I/O port bus, and drives the BOTSIM's motor control and configuration inputs. Captures a coherent snapshot of all six BOTSIM registers on each update, raises a PicoBlaze interrupt, and tracks missed updates. Sits between the `bot` instance and the application kcpsm6 in the top level.

## Interface
- PORT_BASE, 8'h00: I/O base address; bits [2:0] must be 0; block decodes port_id[7:3] == PORT_BASE[7:3].
- CONFIG_RESET, 8'h00: reset value of Bot_Config_out.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- port_id  in  8  PicoBlaze port address.
- out_port  in  8  PicoBlaze write data.
- write_strobe  in  1  write qualifier, one cycle.
- read_strobe  in  1  read qualifier, one cycle.
- in_port  out  8  registered read data.
- interrupt  out  1  interrupt request to application PicoBlaze.
- interrupt_ack  in  1  PicoBlaze interrupt acknowledge, one cycle.
- LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in  in  8 each  BOTSIM register outputs.
- upd_sysregs  in  1  BOTSIM update flag (level or pulse).
- MotCtl_out  out  8  motor control to BOTSIM.
- Bot_Config_out  out  8  configuration to BOTSIM.

## Operation
- Read map (offset = port_id[2:0]): 0 LocX, 1 LocY, 2 Sensors, 3 BotInfo, 4 LMDist, 5 RMDist (all snapshot copies), 6 Status {6'b0, irq_pend, new_data}, 7 Overrun count.
- Write map (write_strobe and address match): 0 MotCtl_out <= out_port; 1 Bot_Config_out <= out_port; 2 ACK (data ignored) clears new_data; 3 clears overrun count; 4–7 ignored.
- Update detect: upd_sysregs registered once; capture event = rising edge (upd & ~upd_d). Level held high produces one event.
- On capture: all six shadow registers load in the same cycle from *_in; new_data <= 1; irq_pend <= 1.
- Overrun: capture while new_data already 1 increments overrun count, saturating at 8'hFF.
- Interrupt: interrupt = irq_pend; irq_pend cleared by interrupt_ack.
- Simultaneous events: capture + ACK write same cycle -> new_data = 1, no overrun increment. Capture + interrupt_ack same cycle -> irq_pend stays 1. Overrun increment + clear-overrun write same cycle -> count = 0.
- Unmatched port_id: in_port = 8'h00; no state change.
- Reads have no side effects.

## Timing
- Reset values: in_port 0, interrupt 0, MotCtl_out 8'h00 (stop), Bot_Config_out CONFIG_RESET, shadows 0, new_data 0, overrun 0, upd_d 0.
- in_port registered: reflects port_id presented in cycle N at cycle N+1 (every cycle, independent of read_strobe).
- Capture: upd_sysregs rises in cycle N -> edge detected N+1 -> shadows, new_data, interrupt valid N+2.
- Writes: outputs update the cycle after write_strobe.
- Reset asserted mid-operation clears everything asynchronously; first capture after release requires a fresh rising edge of upd_sysregs (upd_d resets to 0, so a high level at release counts as an edge).

## Configuration
- BOTIF_OVERRUN_CNT_EN defined: overrun counter, offset-7 read and offset-3 clear implemented as above.
- Undefined: counter not built; offset 7 reads 8'h00; offset-3 write ignored; all other behaviour identical.

## Structure
- Package bot_if_pkg: read/write offset constants (RD_LOCX..RD_OVERRUN, WR_MOTCTL, WR_CONFIG, WR_ACK, WR_CLR_OVR), status bit indices, MOTCTL_STOP = 8'h00.
- One sub-module bot_if_snapshot: edge detector plus six shadow registers, outputs capture pulse and snapshot bus.

## Test plan
- Reset with upd_sysregs low -> all outputs at reset values, Bot_Config_out = CONFIG_RESET; reads of offsets 0–7 return 0.
- Drive LocX_in=8'h12, LocY_in=8'h34, Sensors_in=8'h05, BotInfo_in=8'h81, pulse upd_sysregs -> interrupt high 2 cycles later, reads return 12/34/05/81, Status = 8'h03; change *_in afterward -> reads unchanged.
- interrupt_ack -> interrupt low, Status = 8'h01; write offset 2 -> Status = 8'h00.
- Three captures without ACK -> Overrun reads 8'h02; 300 captures -> 8'hFF; write offset 3 -> 8'h00 (macro off: always 8'h00).
- Write 8'h5A to offset 0 and 8'h03 to offset 1 with PORT_BASE=8'h10 (port_id 8'h10, 8'h11) -> MotCtl_out=8'h5A, Bot_Config_out=8'h03; same writes at port_id 8'h20 -> no change.
- Capture coincident with ACK write and with interrupt_ack -> new_data = 1, irq_pend = 1, overrun unchanged; assert reset mid-sequence -> all state cleared immediately.
